// File: rtl/register_bank.sv
// Bank of NUM_REGS registers: one write port with load/inc/dec,
// one masked bus read port, and registered carry/zero flags.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load/i_inc/i_dec  write ops on register i_wsel
//   i_wsel, i_D         write select and write data
//   i_enable            drive selected register onto o_Q
//   i_only_lower        zero o_Q bits [WIDTH-1:LOW_BITS]
//   i_rsel              read select
//   o_Q                 bus read data (combinational)
//   o_carry, o_zero     flags from the last load/inc/dec
module register_bank #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned LOW_BITS = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int unsigned SEL_W = $clog2(NUM_REGS)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic [SEL_W-1:0] i_wsel,
   input  logic [WIDTH-1:0] i_D,
   input  logic             i_enable,
   input  logic             i_only_lower,
   input  logic [SEL_W-1:0] i_rsel,
   output logic [WIDTH-1:0] o_Q,
   output logic             o_carry,
   output logic             o_zero
);

   localparam logic [WIDTH-1:0] LOW_MASK =
      ~({WIDTH{1'b1}} << LOW_BITS);

   logic [WIDTH-1:0] regs [NUM_REGS];
   logic             carry_q;
   logic             zero_q;

   logic             wsel_ok;
   logic             rsel_ok;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] nxt;
   logic             we;
   logic             carry_n;
   logic             zero_n;
   logic [WIDTH-1:0] rd;

   // Select range checks only matter when the bank
   // size is not a power of two.
   if (NUM_REGS == (1 << SEL_W)) begin : g_full
      assign wsel_ok = 1'b1;
      assign rsel_ok = 1'b1;
   end else begin : g_part
      localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REGS - 1);
      assign wsel_ok = (i_wsel <= LAST);
      assign rsel_ok = (i_rsel <= LAST);
   end

   always_comb begin
      cur     = '0;
      nxt     = '0;
      we      = 1'b0;
      carry_n = carry_q;
      zero_n  = zero_q;
      if (wsel_ok) begin
         cur = regs[i_wsel];
         if (i_load) begin
            we      = 1'b1;
            nxt     = i_D;
            carry_n = 1'b0;
            zero_n  = (i_D == '0);
         end else if (i_inc && !i_dec) begin
            we      = 1'b1;
            nxt     = cur + 1'b1;
            carry_n = &cur;
            zero_n  = (nxt == '0);
         end else if (i_dec && !i_inc) begin
            we      = 1'b1;
            nxt     = cur - 1'b1;
            carry_n = (cur == '0);
            zero_n  = (nxt == '0);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= RST_VAL;
         end
         carry_q <= 1'b0;
         zero_q  <= (RST_VAL == '0);
      end else if (we) begin
         regs[i_wsel] <= nxt;
         carry_q      <= carry_n;
         zero_q       <= zero_n;
      end
   end

   always_comb begin
      rd = '0;
      if (rsel_ok) begin
         rd = regs[i_rsel];
      end
      if (i_only_lower) begin
         rd = rd & LOW_MASK;
      end
      o_Q = i_enable ? rd : '0;
   end

   assign o_carry = carry_q;
   assign o_zero  = zero_q;

endmodule
